// File: rtl/dm_wb_cache.sv
// Direct-mapped, write-back, write-allocate cache.
// The core side takes single-word loads and stores with byte enables. A hit
// completes in the same cycle. A miss writes back a dirty victim if there is
// one, then fills the line, then completes as a hit on the retry cycle.
module dm_wb_cache #(
  parameter int SIZE      = 32768,
  parameter int LINE_SIZE = 256,
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   req_valid_i,
  input  logic                   req_write_i,
  input  logic [ADDR_SIZE-1:0]   req_addr_i,
  input  logic [WORD_SIZE-1:0]   req_wdata_i,
  input  logic [WORD_SIZE/8-1:0] req_be_i,
  output logic [WORD_SIZE-1:0]   req_rdata_o,
  output logic                   req_ready_o,
  output logic                   mem_valid_o,
  output logic                   mem_write_o,
  output logic [ADDR_SIZE-1:0]   mem_addr_o,
  output logic [LINE_SIZE-1:0]   mem_wdata_o,
  input  logic [LINE_SIZE-1:0]   mem_rdata_i,
  input  logic                   mem_ready_i
);

  localparam int NUM_LINES      = SIZE / LINE_SIZE;
  localparam int WORDS_PER_LINE = LINE_SIZE / WORD_SIZE;
  localparam int BYTES_PER_WORD = WORD_SIZE / 8;
  localparam int OFFSET_BITS    = $clog2(LINE_SIZE / 8);
  localparam int INDEX_BITS     = $clog2(NUM_LINES);
  localparam int TAG_BITS       = ADDR_SIZE - INDEX_BITS - OFFSET_BITS;
  localparam int WORD_BITS      = $clog2(WORDS_PER_LINE);
  localparam int BYTE_BITS      = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    LOOKUP,
    WRITEBACK,
    FILL
  } state_e;

  // Per-line state and storage.
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
  logic [LINE_SIZE-1:0] data_mem [NUM_LINES];

  state_e                state_q, state_d;
  logic [TAG_BITS-1:0]   miss_tag_q, miss_tag_d;
  logic [INDEX_BITS-1:0] miss_index_q, miss_index_d;

  // Request address fields.
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_index;
  logic [WORD_BITS-1:0]  req_word;
  logic                  unused_addr_bits;

  assign req_tag          = req_addr_i[ADDR_SIZE-1 -: TAG_BITS];
  assign req_index        = req_addr_i[OFFSET_BITS +: INDEX_BITS];
  assign req_word         = req_addr_i[BYTE_BITS +: WORD_BITS];
  assign unused_addr_bits = ^req_addr_i[BYTE_BITS-1:0];

  // Single write port into the tag and data arrays, shared by store and fill.
  logic                  data_we;
  logic                  tag_we;
  logic [INDEX_BITS-1:0] wr_index;
  logic [LINE_SIZE-1:0]  wr_line;
  logic [TAG_BITS-1:0]   wr_tag;

  logic [LINE_SIZE-1:0]  lookup_line;
  logic [LINE_SIZE-1:0]  store_line;
  logic                  hit;

  // Read the indexed line, select the requested word, and detect a hit.
  always_comb begin
    lookup_line = data_mem[req_index];
    req_rdata_o = lookup_line[int'(req_word)*WORD_SIZE +: WORD_SIZE];
    hit         = req_valid_i && valid_q[req_index] && (tag_mem[req_index] == req_tag);
  end

  // Merge the enabled store bytes into the selected word of the indexed line.
  always_comb begin
    store_line = lookup_line;
    for (int b = 0; b < BYTES_PER_WORD; b++) begin
      if (req_be_i[b]) begin
        store_line[int'(req_word)*WORD_SIZE + b*8 +: 8] = req_wdata_i[b*8 +: 8];
      end
    end
  end

  // Next-state logic, handshake outputs and array write controls.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    miss_tag_d   = miss_tag_q;
    miss_index_d = miss_index_q;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    wr_index     = req_index;
    wr_line      = store_line;
    wr_tag       = miss_tag_q;
    req_ready_o  = 1'b0;
    mem_valid_o  = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = data_mem[miss_index_q];

    case (state_q)
      LOOKUP: begin
        if (hit) begin
          req_ready_o = 1'b1;
          if (req_write_i) begin
            data_we            = 1'b1;
            dirty_d[req_index] = 1'b1;
          end
        end else if (req_valid_i) begin
          // Latch the miss so the transfer finishes even if the core withdraws.
          miss_tag_d   = req_tag;
          miss_index_d = req_index;
          if (valid_q[req_index] && dirty_q[req_index]) begin
            state_d = WRITEBACK;
          end else begin
            state_d = FILL;
          end
        end
      end

      WRITEBACK: begin
        mem_valid_o = 1'b1;
        mem_write_o = 1'b1;
        mem_addr_o  = {tag_mem[miss_index_q], miss_index_q, {OFFSET_BITS{1'b0}}};
        if (mem_ready_i) begin
          dirty_d[miss_index_q] = 1'b0;
          state_d               = FILL;
        end
      end

      FILL: begin
        mem_valid_o = 1'b1;
        mem_addr_o  = {miss_tag_q, miss_index_q, {OFFSET_BITS{1'b0}}};
        if (mem_ready_i) begin
          data_we               = 1'b1;
          tag_we                = 1'b1;
          wr_index              = miss_index_q;
          wr_line               = mem_rdata_i;
          valid_d[miss_index_q] = 1'b1;
          dirty_d[miss_index_q] = 1'b0;
          state_d               = LOOKUP;
        end
      end

      default: state_d = LOOKUP;
    endcase
  end

  // Control state: FSM, per-line valid/dirty bits, and the latched miss address.
  always_ff @(posedge clk_i or negedge reset_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!reset_i) begin
      state_q      <= LOOKUP;
      valid_q      <= '0;
      dirty_q      <= '0;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      miss_tag_q   <= miss_tag_d;
      miss_index_q <= miss_index_d;
    end
  end

  // Tag and data arrays.
  always_ff @(posedge clk_i) begin
    // NOTE: the arrays carry no reset; the cleared valid bits make their
    // contents unobservable, and leaving them unreset lets them map to RAM.
    if (data_we) begin
      data_mem[wr_index] <= wr_line;
    end
    if (tag_we) begin
      tag_mem[wr_index] <= wr_tag;
    end
  end

endmodule

// File: tb/tb_dm_wb_cache.sv
// Directed testbench for dm_wb_cache with a fixed-latency line memory model.
module tb_dm_wb_cache;

  localparam int LAT = 5;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         req_valid_i;
  logic         req_write_i;
  logic [31:0]  req_addr_i;
  logic [31:0]  req_wdata_i;
  logic [3:0]   req_be_i;
  logic [31:0]  req_rdata_o;
  logic         req_ready_o;
  logic         mem_valid_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i = '0;
  logic         mem_ready_i = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic         w;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;

  txn_t        txq[$];
  logic [31:0] wmem [logic [31:0]];
  int          cnt = 0;

  always #5 clk_i = ~clk_i;

  dm_wb_cache dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_be_i    (req_be_i),
    .req_rdata_o (req_rdata_o),
    .req_ready_o (req_ready_o),
    .mem_valid_o (mem_valid_o),
    .mem_write_o (mem_write_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ready_i (mem_ready_i)
  );

  // Backing memory: written words are kept, untouched words follow a pattern.
  function automatic logic [31:0] get_word(input logic [31:0] a);
    if (wmem.exists(a)) return wmem[a];
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Memory side: log completed transfers, store write-backs, count wait cycles.
  always @(posedge clk_i) begin
    if (mem_valid_o && mem_ready_i) begin
      txq.push_back('{mem_write_o, mem_addr_o, mem_wdata_o});
      if (mem_write_o) begin
        for (int w = 0; w < 8; w++) wmem[mem_addr_o + 32'(w*4)] = mem_wdata_o[w*32 +: 32];
      end
      cnt = 0;
    end else if (mem_valid_o) begin
      cnt = cnt + 1;
    end else begin
      cnt = 0;
    end
  end

  // Memory responds in the LAT-th cycle of each transfer.
  always @(negedge clk_i) begin
    mem_ready_i = mem_valid_o && (cnt == LAT-1);
    for (int w = 0; w < 8; w++) mem_rdata_i[w*32 +: 32] = get_word(mem_addr_o + 32'(w*4));
  end

  // One core request; starts just after a rising edge, returns likewise.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output int cyc);
    logic done;
    done        = 1'b0;
    rd          = 'x;
    cyc         = 0;
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wd;
    req_be_i    = be;
    while (!done && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
      if (req_ready_o) begin
        rd   = req_rdata_o;
        done = 1'b1;
      end
    end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL req_timeout addr=%h: no req_ready_o after %0d cycles, required ready", addr, cyc);
    end
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i     = 1'b0;
    req_valid_i = 1'b1;
    req_write_i = 1'b0;
    req_addr_i  = 32'h40;
    req_wdata_i = '0;
    req_be_i    = '0;
    repeat (2) @(negedge clk_i);
    tests_run++;
    if (mem_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mem_valid: got %b, expected 0", mem_valid_o);
    end
    tests_run++;
    if (req_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_req_ready: got %b, expected 0", req_ready_o);
    end
    req_valid_i = 1'b0;
    @(posedge clk_i);
    #1 reset_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_fill_load();
    logic [31:0] rd;
    int          cyc;
    txq.delete();
    do_req(1'b0, 32'h40, '0, '0, rd, cyc);
    tests_run++;
    if (cyc != 7) begin
      tests_failed++;
      $display("FAIL fill_latency: got %0d cycles, expected 7", cyc);
    end
    tests_run++;
    if (rd !== 32'h1111_2222) begin
      tests_failed++;
      $display("FAIL fill_rdata: got %h, expected 11112222", rd);
    end
    tests_run++;
    if (txq.size() != 1) begin
      tests_failed++;
      $display("FAIL fill_txn_count: got %0d, expected 1", txq.size());
    end else begin
      tests_run++;
      if (txq[0].w !== 1'b0 || txq[0].addr !== 32'h40) begin
        tests_failed++;
        $display("FAIL fill_txn: got w=%b addr=%h, expected w=0 addr=00000040", txq[0].w, txq[0].addr);
      end
    end
  endtask

  task automatic test_same_line_hit();
    logic [31:0] rd;
    int          cyc;
    txq.delete();
    do_req(1'b0, 32'h44, '0, 4'hF, rd, cyc);
    tests_run++;
    if (cyc != 1 || rd !== 32'hC0DE_0044) begin
      tests_failed++;
      $display("FAIL same_line_hit: got cyc=%0d data=%h, expected cyc=1 data=c0de0044", cyc, rd);
    end
    tests_run++;
    if (txq.size() != 0) begin
      tests_failed++;
      $display("FAIL same_line_traffic: got %0d transfers, expected 0", txq.size());
    end
  endtask

  task automatic test_store_hit();
    logic [31:0] rd;
    int          cyc;
    txq.delete();
    do_req(1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011, rd, cyc);
    tests_run++;
    if (cyc != 1) begin
      tests_failed++;
      $display("FAIL store_hit_latency: got %0d cycles, expected 1", cyc);
    end
    do_req(1'b0, 32'h40, '0, '0, rd, cyc);
    tests_run++;
    if (cyc != 1 || rd !== 32'h1111_BEEF) begin
      tests_failed++;
      $display("FAIL store_readback: got cyc=%0d data=%h, expected cyc=1 data=1111beef", cyc, rd);
    end
    tests_run++;
    if (txq.size() != 0) begin
      tests_failed++;
      $display("FAIL store_traffic: got %0d transfers, expected 0", txq.size());
    end
  endtask

  task automatic test_back_to_back();
    req_valid_i = 1'b1;
    req_write_i = 1'b0;
    req_addr_i  = 32'h40;
    @(negedge clk_i);
    tests_run++;
    if (req_ready_o !== 1'b1 || req_rdata_o !== 32'h1111_BEEF) begin
      tests_failed++;
      $display("FAIL b2b_first: got ready=%b data=%h, expected ready=1 data=1111beef", req_ready_o, req_rdata_o);
    end
    @(posedge clk_i);
    #1 req_addr_i = 32'h5C;
    @(negedge clk_i);
    tests_run++;
    if (req_ready_o !== 1'b1 || req_rdata_o !== 32'hC0DE_005C) begin
      tests_failed++;
      $display("FAIL b2b_second: got ready=%b data=%h, expected ready=1 data=c0de005c", req_ready_o, req_rdata_o);
    end
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    tests_run++;
    if (req_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_ready: got %b, expected 0", req_ready_o);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_dirty_evict();
    logic [31:0] rd;
    int          cyc;
    txq.delete();
    do_req(1'b0, 32'h1040, '0, '0, rd, cyc);
    tests_run++;
    if (cyc != 12 || rd !== 32'hC0DE_1040) begin
      tests_failed++;
      $display("FAIL evict_load: got cyc=%0d data=%h, expected cyc=12 data=c0de1040", cyc, rd);
    end
    tests_run++;
    if (txq.size() != 2) begin
      tests_failed++;
      $display("FAIL evict_txn_count: got %0d, expected 2", txq.size());
    end else begin
      tests_run++;
      if (txq[0].w !== 1'b1 || txq[0].addr !== 32'h40 || txq[0].data[31:0] !== 32'h1111_BEEF) begin
        tests_failed++;
        $display("FAIL evict_writeback: got w=%b addr=%h word0=%h, expected w=1 addr=00000040 word0=1111beef",
                 txq[0].w, txq[0].addr, txq[0].data[31:0]);
      end
      tests_run++;
      if (txq[1].w !== 1'b0 || txq[1].addr !== 32'h1040) begin
        tests_failed++;
        $display("FAIL evict_fill: got w=%b addr=%h, expected w=0 addr=00001040", txq[1].w, txq[1].addr);
      end
    end
  endtask

  task automatic test_clean_conflict();
    logic [31:0] rd;
    int          cyc;
    txq.delete();
    do_req(1'b0, 32'h40, '0, '0, rd, cyc);
    tests_run++;
    if (cyc != 7 || rd !== 32'h1111_BEEF) begin
      tests_failed++;
      $display("FAIL clean_load: got cyc=%0d data=%h, expected cyc=7 data=1111beef", cyc, rd);
    end
    tests_run++;
    if (txq.size() != 1) begin
      tests_failed++;
      $display("FAIL clean_txn_count: got %0d, expected 1", txq.size());
    end else begin
      tests_run++;
      if (txq[0].w !== 1'b0 || txq[0].addr !== 32'h40) begin
        tests_failed++;
        $display("FAIL clean_fill: got w=%b addr=%h, expected w=0 addr=00000040", txq[0].w, txq[0].addr);
      end
    end
  endtask

  task automatic test_byte_enables();
    logic [31:0] rd;
    int          cyc;
    do_req(1'b1, 32'h48, 32'hAABB_CCDD, 4'b1010, rd, cyc);
    do_req(1'b0, 32'h48, '0, 4'b0000, rd, cyc);
    tests_run++;
    if (cyc != 1 || rd !== 32'hAADE_CC48) begin
      tests_failed++;
      $display("FAIL byte_enables: got cyc=%0d data=%h, expected cyc=1 data=aadecc48", cyc, rd);
    end
  endtask

  task automatic test_reset_during_fill();
    logic [31:0] rd;
    int          cyc;
    txq.delete();
    req_valid_i = 1'b1;
    req_write_i = 1'b0;
    req_addr_i  = 32'h3000;
    repeat (2) @(negedge clk_i);
    tests_run++;
    if (mem_valid_o !== 1'b1 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h3000) begin
      tests_failed++;
      $display("FAIL mid_fill: got valid=%b write=%b addr=%h, expected valid=1 write=0 addr=00003000",
               mem_valid_o, mem_write_o, mem_addr_o);
    end
    #1 reset_i = 1'b0;
    #1;
    tests_run++;
    if (mem_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got mem_valid=%b req_ready=%b, expected 0 0", mem_valid_o, req_ready_o);
    end
    req_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    do_req(1'b0, 32'h40, '0, '0, rd, cyc);
    tests_run++;
    if (cyc != 7 || rd !== 32'h1111_BEEF || txq.size() != 1) begin
      tests_failed++;
      $display("FAIL post_reset_miss: got cyc=%0d data=%h txns=%0d, expected cyc=7 data=1111beef txns=1",
               cyc, rd, txq.size());
    end
    do_req(1'b0, 32'h48, '0, '0, rd, cyc);
    tests_run++;
    if (cyc != 1 || rd !== 32'hC0DE_0048) begin
      tests_failed++;
      $display("FAIL post_reset_line: got cyc=%0d data=%h, expected cyc=1 data=c0de0048", cyc, rd);
    end
  endtask

  initial begin
    wmem[32'h40] = 32'h1111_2222;
    test_reset();
    test_fill_load();
    test_same_line_hit();
    test_store_hit();
    test_back_to_back();
    test_dirty_evict();
    test_clean_conflict();
    test_byte_enables();
    test_reset_during_fill();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
